counter_cmd_ctrl: RTL and testbench

Front-end command generator for the 3-bit counter stage. It takes two raw, bouncing push-button inputs and produces the counter's `set` and `load` controls as clean, registered single-cycle pulses. The `load` button auto-repeats while held. The block sits directly upstream of the counter, and its `set`/`load` outputs wire straight to the counter's `set`/`load` inputs.

---
 rtl/counter_cmd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_counter_cmd_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl: debounces two raw push-buttons and issues clean, registered
// single-cycle set/load command pulses for the downstream 3-bit counter.
// The load command auto-repeats while its button stays held.
//
// Ports:
//   clk        - clock, all state on rising edge
//   reset_n    - asynchronous active-low reset
//   btn_set    - raw set button (async, active-high, bouncy)
//   btn_load   - raw load button (async, active-high, bouncy)
//   set        - one-cycle pulse per qualified set press
//   load       - one-cycle pulse per qualified load press and per repeat
//   set_held   - debounced set button level
//   load_held  - debounced load button level
module counter_cmd_ctrl #(
    parameter int unsigned DB_CYCLES  = 8,
    parameter int unsigned RPT_CYCLES = 32,
    parameter int unsigned CW         = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_set,
    input  logic btn_load,
    output logic set,
    output logic load,
    output logic set_held,
    output logic load_held
);

    localparam int unsigned NCH = 2;   // channel 0 = set, channel 1 = load
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST = CW'(RPT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        REL     = 2'd3
    } state_t;

    logic [NCH-1:0] w_btn;
    logic [NCH-1:0] r_s1;
    logic [NCH-1:0] r_s2;

    state_t        r_state     [NCH];
    state_t        w_state_nxt [NCH];
    logic [CW-1:0] r_dc        [NCH];
    logic [CW-1:0] w_dc_nxt    [NCH];
    logic [NCH-1:0] w_press;

    logic [CW-1:0] r_rc;
    logic [CW-1:0] w_rc_nxt;
    logic          w_rpt;

    logic w_set_evt;
    logic w_load_evt;
    logic r_set;
    logic r_load;
    logic r_load_pend;
    logic r_set_held;
    logic r_load_held;

    assign w_btn = {btn_load, btn_set};

    // Two-flop synchronizers for both buttons
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_btn;
            r_s2 <= r_s1;
        end
    end

    // Channel FSM state and debounce counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= IDLE;
                r_dc[i]    <= '0;
            end
            r_rc <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_dc[i]    <= w_dc_nxt[i];
            end
            r_rc <= w_rc_nxt;
        end
    end

    // Channel next-state logic and press events
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_dc_nxt[i]    = r_dc[i];
            w_press[i]     = 1'b0;
            case (r_state[i])
                IDLE: begin
                    if (r_s2[i]) begin
                        w_state_nxt[i] = ARM;
                        w_dc_nxt[i]    = '0;
                    end
                end
                ARM: begin
                    if (!r_s2[i]) begin
                        w_state_nxt[i] = IDLE;
                    end else if (r_dc[i] == DB_LAST) begin
                        w_state_nxt[i] = PRESSED;
                        w_press[i]     = 1'b1;
                    end else begin
                        w_dc_nxt[i] = r_dc[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!r_s2[i]) begin
                        w_state_nxt[i] = REL;
                        w_dc_nxt[i]    = '0;
                    end
                end
                REL: begin
                    if (r_s2[i]) begin
                        w_state_nxt[i] = PRESSED;
                    end else if (r_dc[i] == DB_LAST) begin
                        w_state_nxt[i] = IDLE;
                    end else begin
                        w_dc_nxt[i] = r_dc[i] + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = IDLE;
                end
            endcase
        end
    end

    // Load repeat counter: runs only while staying in PRESSED, held at 0
    // otherwise so every entry to PRESSED starts a fresh repeat phase.
    always_comb begin
        w_rc_nxt = '0;
        w_rpt    = 1'b0;
        if (r_state[1] == PRESSED && r_s2[1]) begin
            if (r_rc == RPT_LAST) begin
                w_rpt = 1'b1;
            end else begin
                w_rc_nxt = r_rc + CW'(1);
            end
        end
    end

    assign w_set_evt  = w_press[0];
    assign w_load_evt = w_press[1] | w_rpt;

    // Output arbitration: set wins a collision, load is deferred one cycle
    // via load_pend; a pending load merges with any new load event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_set       <= 1'b0;
            r_load      <= 1'b0;
            r_load_pend <= 1'b0;
            r_set_held  <= 1'b0;
            r_load_held <= 1'b0;
        end else begin
            r_set       <= w_set_evt;
            r_load      <= ~w_set_evt & (w_load_evt | r_load_pend);
            r_load_pend <= w_set_evt & (w_load_evt | r_load_pend);
            r_set_held  <= (w_state_nxt[0] == PRESSED) || (w_state_nxt[0] == REL);
            r_load_held <= (w_state_nxt[1] == PRESSED) || (w_state_nxt[1] == REL);
        end
    end

    assign set       = r_set;
    assign load      = r_load;
    assign set_held  = r_set_held;
    assign load_held = r_load_held;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb_counter_cmd_ctrl: directed bench for counter_cmd_ctrl with default
// parameters. Edge numbering: the first edge after a button change is E0.
module tb_counter_cmd_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_set;
    logic btn_load;
    logic set;
    logic load;
    logic set_held;
    logic load_held;

    int n_checks = 0;
    int n_errors = 0;

    // per-window observation record
    int cyc;
    int set_cnt, load_cnt, overlap;
    int set_e;
    int load_e [8];
    int sh_rise, sh_fall, lh_rise, lh_fall, lh_fall_cnt, lh_max;
    logic p_sh, p_lh;

    counter_cmd_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_set   (btn_set),
        .btn_load  (btn_load),
        .set       (set),
        .load      (load),
        .set_held  (set_held),
        .load_held (load_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        cyc = 0; set_cnt = 0; load_cnt = 0; overlap = 0; set_e = -1;
        for (int i = 0; i < 8; i++) load_e[i] = -1;
        sh_rise = -1; sh_fall = -1; lh_rise = -1; lh_fall = -1;
        lh_fall_cnt = 0; lh_max = 0;
        p_sh = set_held; p_lh = load_held;
    endtask

    // advance one edge, sample 1 time unit after it, record events at index cyc
    task automatic step();
        @(posedge clk);
        #1;
        if (set) begin set_cnt++; set_e = cyc; end
        if (load) begin
            if (load_cnt < 8) load_e[load_cnt] = cyc;
            load_cnt++;
        end
        if (set && load) overlap++;
        if (set_held && !p_sh) sh_rise = cyc;
        if (!set_held && p_sh) sh_fall = cyc;
        if (load_held && !p_lh) lh_rise = cyc;
        if (!load_held && p_lh) begin lh_fall = cyc; lh_fall_cnt++; end
        if (load_held) lh_max = 1;
        p_sh = set_held; p_lh = load_held;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_set"},       int'(set),       0);
        chk({tag, "_load"},      int'(load),      0);
        chk({tag, "_set_held"},  int'(set_held),  0);
        chk({tag, "_load_held"}, int'(load_held), 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        btn_set  = 1'b0;
        btn_load = 1'b0;
        #23;
        chk_outs_zero("rst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        run(3);

        // clean set press and release
        btn_set = 1'b1;
        clear_obs();
        run(20);
        chk("set_cnt",      set_cnt, 1);
        chk("set_edge",     set_e,   10);
        chk("set_held_up",  sh_rise, 10);
        chk("set_no_load",  load_cnt, 0);
        btn_set = 1'b0;
        clear_obs();
        run(15);
        chk("set_held_dn",  sh_fall, 10);
        chk("set_rel_cnt",  set_cnt, 0);

        // glitches of 1..7 cycles never qualify
        clear_obs();
        for (int w = 1; w <= 7; w++) begin
            btn_load = 1'b1;
            run(w);
            btn_load = 1'b0;
            run(12);
        end
        chk("glitch_load", load_cnt, 0);
        chk("glitch_held", lh_max,   0);

        // long hold with auto-repeat, release at edge 120
        clear_obs();
        for (int i = 0; i < 140; i++) begin
            btn_load = (i < 120);
            step();
        end
        chk("rpt_cnt",     load_cnt,  4);
        chk("rpt_e0",      load_e[0], 10);
        chk("rpt_e1",      load_e[1], 42);
        chk("rpt_e2",      load_e[2], 74);
        chk("rpt_e3",      load_e[3], 106);
        chk("rpt_held_up", lh_rise,   10);
        chk("rpt_held_dn", lh_fall,   130);

        // bounce low for 3 cycles at E30: re-entry at E35, next repeat E67
        clear_obs();
        for (int i = 0; i < 90; i++) begin
            btn_load = !(i >= 30 && i < 33);
            step();
        end
        chk("bnc_cnt",     load_cnt,    2);
        chk("bnc_e0",      load_e[0],   10);
        chk("bnc_e1",      load_e[1],   67);
        chk("bnc_held_dn", lh_fall_cnt, 0);
        chk("bnc_held",    int'(load_held), 1);
        btn_load = 1'b0;
        run(15);

        // simultaneous presses: set wins, load deferred one cycle
        btn_set  = 1'b1;
        btn_load = 1'b1;
        clear_obs();
        run(30);
        chk("both_set_cnt",  set_cnt,   1);
        chk("both_set_e",    set_e,     10);
        chk("both_load_cnt", load_cnt,  1);
        chk("both_load_e",   load_e[0], 11);
        chk("both_overlap",  overlap,   0);
        btn_set  = 1'b0;
        btn_load = 1'b0;
        run(15);

        // reset during ARM, button held across reset release
        btn_set = 1'b1;
        clear_obs();
        run(5);
        reset_n = 1'b0;
        #2;
        chk_outs_zero("rst_arm");
        run(2);
        reset_n = 1'b1;
        clear_obs();
        run(20);
        chk("rarm_set_cnt", set_cnt, 1);
        chk("rarm_set_e",   set_e,   10);
        btn_set = 1'b0;
        run(15);

        // reset during PRESSED, button held across reset release
        btn_load = 1'b1;
        clear_obs();
        run(12);
        chk("rprs_held_pre", int'(load_held), 1);
        reset_n = 1'b0;
        #2;
        chk_outs_zero("rst_prs");
        run(2);
        reset_n = 1'b1;
        clear_obs();
        run(20);
        chk("rprs_load_cnt", load_cnt,  1);
        chk("rprs_load_e",   load_e[0], 10);
        chk("rprs_held_up",  lh_rise,   10);
        btn_load = 1'b0;
        run(15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
